// File: rtl/pipe_reg_execute.sv
// Decode->Execute pipeline register with built-in load/use and mispredict bubble injection.
// Drives fetch/decode stall and decode squash controls, and keeps saturating hazard counters.
module pipe_reg_execute #(
    parameter int         CNT_W = 32,
    parameter logic [3:0] RNONE = 4'hF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ext_stall,
    input  logic [3:0]       d_stat,
    input  logic [3:0]       d_icode,
    input  logic [3:0]       d_ifun,
    input  logic [63:0]      d_valC,
    input  logic [63:0]      d_valA,
    input  logic [63:0]      d_valB,
    input  logic [3:0]       d_dstE,
    input  logic [3:0]       d_dstM,
    input  logic [3:0]       d_srcA,
    input  logic [3:0]       d_srcB,
    input  logic             e_Cnd,
    output logic [3:0]       E_stat,
    output logic [3:0]       E_icode,
    output logic [3:0]       E_ifun,
    output logic [63:0]      E_valC,
    output logic [63:0]      E_valA,
    output logic [63:0]      E_valB,
    output logic [3:0]       E_dstE,
    output logic [3:0]       E_dstM,
    output logic [3:0]       E_srcA,
    output logic [3:0]       E_srcB,
    output logic             F_stall,
    output logic             D_stall,
    output logic             D_bubble,
    output logic [CNT_W-1:0] lu_count,
    output logic [CNT_W-1:0] mp_count
);

    localparam logic [3:0] STAT_BUB  = 4'd0;
    localparam logic [3:0] I_NOP     = 4'd1;
    localparam logic [3:0] I_MRMOVQ  = 4'd5;
    localparam logic [3:0] I_JXX     = 4'd7;
    localparam logic [3:0] I_POPQ    = 4'd11;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic isLoad;
    logic loadUse;
    logic mispredict;
    logic insertBubble;

    // Hazards are judged purely from what already sits in E, so a bubble clears them.
    assign isLoad       = (E_icode == I_MRMOVQ) || (E_icode == I_POPQ);
    assign loadUse      = isLoad && (E_dstM != RNONE) &&
                          ((E_dstM == d_srcA) || (E_dstM == d_srcB));
    assign mispredict   = (E_icode == I_JXX) && !e_Cnd;
    assign insertBubble = loadUse || mispredict;

    assign F_stall  = loadUse;
    assign D_stall  = loadUse;
    assign D_bubble = mispredict && !loadUse;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            E_stat  <= STAT_BUB;
            E_icode <= I_NOP;
            E_ifun  <= 4'd0;
            E_valC  <= 64'd0;
            E_valA  <= 64'd0;
            E_valB  <= 64'd0;
            E_dstE  <= RNONE;
            E_dstM  <= RNONE;
            E_srcA  <= RNONE;
            E_srcB  <= RNONE;
        end else if (!ext_stall) begin
            if (insertBubble) begin
                E_stat  <= STAT_BUB;
                E_icode <= I_NOP;
                E_ifun  <= 4'd0;
                E_valC  <= 64'd0;
                E_valA  <= 64'd0;
                E_valB  <= 64'd0;
                E_dstE  <= RNONE;
                E_dstM  <= RNONE;
                E_srcA  <= RNONE;
                E_srcB  <= RNONE;
            end else begin
                E_stat  <= d_stat;
                E_icode <= d_icode;
                E_ifun  <= d_ifun;
                E_valC  <= d_valC;
                E_valA  <= d_valA;
                E_valB  <= d_valB;
                E_dstE  <= d_dstE;
                E_dstM  <= d_dstM;
                E_srcA  <= d_srcA;
                E_srcB  <= d_srcB;
            end
        end
    end

    // One count per inserted bubble; load/use takes the credit when both could apply.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lu_count <= '0;
            mp_count <= '0;
        end else if (!ext_stall) begin
            if (loadUse) begin
                if (lu_count != CNT_MAX) lu_count <= lu_count + CNT_ONE;
            end else if (mispredict) begin
                if (mp_count != CNT_MAX) mp_count <= mp_count + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_pipe_reg_execute.sv
// Directed bench for pipe_reg_execute: a default-width instance plus a 2-bit-counter
// instance driven in parallel so counter saturation is reachable in a short run.
module tb_pipe_reg_execute;

    logic        clk;
    logic        rst_n;
    logic        ext_stall;
    logic [3:0]  d_stat, d_icode, d_ifun;
    logic [63:0] d_valC, d_valA, d_valB;
    logic [3:0]  d_dstE, d_dstM, d_srcA, d_srcB;
    logic        e_Cnd;

    logic [3:0]  E_stat, E_icode, E_ifun;
    logic [63:0] E_valC, E_valA, E_valB;
    logic [3:0]  E_dstE, E_dstM, E_srcA, E_srcB;
    logic        F_stall, D_stall, D_bubble;
    logic [31:0] lu_count, mp_count;

    logic [3:0]  sE_stat, sE_icode, sE_ifun;
    logic [63:0] sE_valC, sE_valA, sE_valB;
    logic [3:0]  sE_dstE, sE_dstM, sE_srcA, sE_srcB;
    logic        sF_stall, sD_stall, sD_bubble;
    logic [1:0]  sLuCount, sMpCount;

    int nChecks = 0;
    int nFail   = 0;

    pipe_reg_execute #(.CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .ext_stall(ext_stall),
        .d_stat(d_stat), .d_icode(d_icode), .d_ifun(d_ifun),
        .d_valC(d_valC), .d_valA(d_valA), .d_valB(d_valB),
        .d_dstE(d_dstE), .d_dstM(d_dstM), .d_srcA(d_srcA), .d_srcB(d_srcB),
        .e_Cnd(e_Cnd),
        .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun),
        .E_valC(E_valC), .E_valA(E_valA), .E_valB(E_valB),
        .E_dstE(E_dstE), .E_dstM(E_dstM), .E_srcA(E_srcA), .E_srcB(E_srcB),
        .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble),
        .lu_count(lu_count), .mp_count(mp_count)
    );

    pipe_reg_execute #(.CNT_W(2)) dutSat (
        .clk(clk), .rst_n(rst_n), .ext_stall(ext_stall),
        .d_stat(d_stat), .d_icode(d_icode), .d_ifun(d_ifun),
        .d_valC(d_valC), .d_valA(d_valA), .d_valB(d_valB),
        .d_dstE(d_dstE), .d_dstM(d_dstM), .d_srcA(d_srcA), .d_srcB(d_srcB),
        .e_Cnd(e_Cnd),
        .E_stat(sE_stat), .E_icode(sE_icode), .E_ifun(sE_ifun),
        .E_valC(sE_valC), .E_valA(sE_valA), .E_valB(sE_valB),
        .E_dstE(sE_dstE), .E_dstM(sE_dstM), .E_srcA(sE_srcA), .E_srcB(sE_srcB),
        .F_stall(sF_stall), .D_stall(sD_stall), .D_bubble(sD_bubble),
        .lu_count(sLuCount), .mp_count(sMpCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setD(input logic [3:0] ic, input logic [63:0] a, input logic [63:0] b,
                        input logic [3:0] dE, input logic [3:0] dM,
                        input logic [3:0] sA, input logic [3:0] sB);
        d_stat  = 4'd1;
        d_icode = ic;
        d_ifun  = 4'd0;
        d_valC  = 64'h1000 + a;
        d_valA  = a;
        d_valB  = b;
        d_dstE  = dE;
        d_dstM  = dM;
        d_srcA  = sA;
        d_srcB  = sB;
    endtask

    task automatic test_reset();
        setD(4'd6, 64'h11, 64'h22, 4'd2, 4'hF, 4'hF, 4'hF);
        tick();
        if (E_icode !== 4'd6) begin $display("FAIL pre_reset_load E_icode got %0d want 6", E_icode); nFail++; end
        nChecks++;
        #3 rst_n = 1'b0;
        #1;
        if (E_icode !== 4'd1) begin $display("FAIL reset E_icode got %0d want 1", E_icode); nFail++; end
        nChecks++;
        if (E_dstE !== 4'hF) begin $display("FAIL reset E_dstE got %h want f", E_dstE); nFail++; end
        nChecks++;
        if (E_valA !== 64'd0) begin $display("FAIL reset E_valA got %h want 0", E_valA); nFail++; end
        nChecks++;
        if (E_stat !== 4'd0) begin $display("FAIL reset E_stat got %0d want 0", E_stat); nFail++; end
        nChecks++;
        if (lu_count !== 32'd0 || mp_count !== 32'd0) begin
            $display("FAIL reset counters got lu=%0d mp=%0d want 0/0", lu_count, mp_count); nFail++;
        end
        nChecks++;
        if (F_stall !== 1'b0 || D_stall !== 1'b0 || D_bubble !== 1'b0) begin
            $display("FAIL reset controls got %b%b%b want 000", F_stall, D_stall, D_bubble); nFail++;
        end
        nChecks++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_pass();
        setD(4'd6, 64'd5, 64'd7, 4'd2, 4'hF, 4'd1, 4'd2);
        tick();
        if (E_icode !== 4'd6 || E_valA !== 64'd5 || E_valB !== 64'd7 || E_dstE !== 4'd2) begin
            $display("FAIL pass_opq got icode=%0d valA=%0d valB=%0d dstE=%0d want 6/5/7/2",
                     E_icode, E_valA, E_valB, E_dstE); nFail++;
        end
        nChecks++;
        if (E_stat !== 4'd1 || E_valC !== 64'h1005 || E_srcA !== 4'd1 || E_srcB !== 4'd2) begin
            $display("FAIL pass_misc got stat=%0d valC=%h srcA=%0d srcB=%0d want 1/1005/1/2",
                     E_stat, E_valC, E_srcA, E_srcB); nFail++;
        end
        nChecks++;
        setD(4'd2, 64'hDEAD_BEEF_0000_0001, 64'h0, 4'd9, 4'hF, 4'd3, 4'hF);
        tick();
        if (E_icode !== 4'd2 || E_valA !== 64'hDEAD_BEEF_0000_0001 || E_dstE !== 4'd9) begin
            $display("FAIL pass_rrmovq got icode=%0d valA=%h dstE=%0d want 2/deadbeef00000001/9",
                     E_icode, E_valA, E_dstE); nFail++;
        end
        nChecks++;
    endtask

    task automatic test_load_use();
        setD(4'd5, 64'hAA, 64'h0, 4'hF, 4'd3, 4'hF, 4'd4);
        tick();
        setD(4'd6, 64'h44, 64'h55, 4'd6, 4'hF, 4'hF, 4'd3);
        #1;
        if (F_stall !== 1'b1 || D_stall !== 1'b1 || D_bubble !== 1'b0) begin
            $display("FAIL lu_controls got F=%b D=%b Db=%b want 1/1/0", F_stall, D_stall, D_bubble); nFail++;
        end
        nChecks++;
        tick();
        if (E_icode !== 4'd1 || E_stat !== 4'd0 || E_dstM !== 4'hF || E_valA !== 64'd0) begin
            $display("FAIL lu_bubble got icode=%0d stat=%0d dstM=%h valA=%h want 1/0/f/0",
                     E_icode, E_stat, E_dstM, E_valA); nFail++;
        end
        nChecks++;
        if (lu_count !== 32'd1 || mp_count !== 32'd0) begin
            $display("FAIL lu_count got lu=%0d mp=%0d want 1/0", lu_count, mp_count); nFail++;
        end
        nChecks++;
        if (F_stall !== 1'b0) begin $display("FAIL lu_selfclear got %b want 0", F_stall); nFail++; end
        nChecks++;
        tick();
        if (E_icode !== 4'd6 || E_valA !== 64'h44) begin
            $display("FAIL lu_resume got icode=%0d valA=%h want 6/44", E_icode, E_valA); nFail++;
        end
        nChecks++;
    endtask

    task automatic test_mispredict();
        setD(4'd7, 64'h0, 64'h0, 4'hF, 4'hF, 4'hF, 4'hF);
        tick();
        setD(4'd6, 64'h21, 64'h0, 4'd1, 4'hF, 4'hF, 4'hF);
        e_Cnd = 1'b0;
        #1;
        if (D_bubble !== 1'b1 || F_stall !== 1'b0) begin
            $display("FAIL mp_controls got Db=%b F=%b want 1/0", D_bubble, F_stall); nFail++;
        end
        nChecks++;
        tick();
        if (E_icode !== 4'd1 || mp_count !== 32'd1 || lu_count !== 32'd1) begin
            $display("FAIL mp_bubble got icode=%0d mp=%0d lu=%0d want 1/1/1", E_icode, mp_count, lu_count); nFail++;
        end
        nChecks++;
        e_Cnd = 1'b1;
        setD(4'd7, 64'h0, 64'h0, 4'hF, 4'hF, 4'hF, 4'hF);
        tick();
        setD(4'd6, 64'h33, 64'h0, 4'd1, 4'hF, 4'hF, 4'hF);
        #1;
        if (D_bubble !== 1'b0) begin $display("FAIL mp_taken_ctrl got %b want 0", D_bubble); nFail++; end
        nChecks++;
        tick();
        if (E_icode !== 4'd6 || E_valA !== 64'h33 || mp_count !== 32'd1) begin
            $display("FAIL mp_taken got icode=%0d valA=%h mp=%0d want 6/33/1", E_icode, E_valA, mp_count); nFail++;
        end
        nChecks++;
    endtask

    task automatic test_rnone();
        setD(4'd11, 64'h0, 64'h0, 4'd4, 4'hF, 4'd4, 4'd4);
        tick();
        setD(4'd6, 64'd9, 64'd1, 4'd0, 4'hF, 4'hF, 4'd8);
        #1;
        if (F_stall !== 1'b0 || D_stall !== 1'b0) begin
            $display("FAIL rnone_ctrl got F=%b D=%b want 0/0", F_stall, D_stall); nFail++;
        end
        nChecks++;
        tick();
        if (E_icode !== 4'd6 || E_valA !== 64'd9 || lu_count !== 32'd1) begin
            $display("FAIL rnone_load got icode=%0d valA=%0d lu=%0d want 6/9/1", E_icode, E_valA, lu_count); nFail++;
        end
        nChecks++;
    endtask

    task automatic test_ext_stall();
        setD(4'd5, 64'hAB, 64'h0, 4'hF, 4'd4, 4'hF, 4'hF);
        tick();
        setD(4'd6, 64'h77, 64'h0, 4'd2, 4'hF, 4'd4, 4'hF);
        ext_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (E_icode !== 4'd5 || E_valA !== 64'hAB || lu_count !== 32'd1 || F_stall !== 1'b1) begin
                $display("FAIL ext_hold[%0d] got icode=%0d valA=%h lu=%0d F=%b want 5/ab/1/1",
                         i, E_icode, E_valA, lu_count, F_stall); nFail++;
            end
            nChecks++;
        end
        ext_stall = 1'b0;
        tick();
        if (E_icode !== 4'd1 || lu_count !== 32'd2) begin
            $display("FAIL ext_release got icode=%0d lu=%0d want 1/2", E_icode, lu_count); nFail++;
        end
        nChecks++;
        tick();
        if (E_icode !== 4'd6 || E_valA !== 64'h77 || lu_count !== 32'd2) begin
            $display("FAIL ext_after got icode=%0d valA=%h lu=%0d want 6/77/2", E_icode, E_valA, lu_count); nFail++;
        end
        nChecks++;
    endtask

    task automatic test_saturate();
        int expLu;
        logic [1:0] expSat;
        expLu = 2;
        for (int i = 0; i < 3; i++) begin
            setD(4'd11, 64'h0, 64'h0, 4'd4, 4'd3, 4'd4, 4'hF);
            tick();
            setD(4'd6, 64'h1, 64'h2, 4'd5, 4'hF, 4'd3, 4'hF);
            tick();
            expLu++;
            expSat = (expLu > 3) ? 2'd3 : 2'(expLu);
            if (lu_count !== 32'(expLu) || sLuCount !== expSat || sE_icode !== 4'd1) begin
                $display("FAIL sat[%0d] got lu=%0d satLu=%0d satIcode=%0d want %0d/%0d/1",
                         i, lu_count, sLuCount, sE_icode, expLu, expSat); nFail++;
            end
            nChecks++;
        end
        if (sMpCount !== 2'd1) begin $display("FAIL sat_mp got %0d want 1", sMpCount); nFail++; end
        nChecks++;
    endtask

    task automatic test_reset_mid_stall();
        setD(4'd5, 64'h5, 64'h0, 4'hF, 4'd3, 4'hF, 4'hF);
        tick();
        setD(4'd6, 64'h6, 64'h0, 4'd1, 4'hF, 4'hF, 4'd3);
        ext_stall = 1'b1;
        tick();
        #3 rst_n = 1'b0;
        #1;
        if (E_icode !== 4'd1 || E_dstM !== 4'hF || F_stall !== 1'b0) begin
            $display("FAIL rst_mid got icode=%0d dstM=%h F=%b want 1/f/0", E_icode, E_dstM, F_stall); nFail++;
        end
        nChecks++;
        if (lu_count !== 32'd0 || mp_count !== 32'd0 || sLuCount !== 2'd0) begin
            $display("FAIL rst_mid_cnt got lu=%0d mp=%0d satLu=%0d want 0/0/0", lu_count, mp_count, sLuCount); nFail++;
        end
        nChecks++;
        ext_stall = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        ext_stall = 1'b0;
        e_Cnd     = 1'b1;
        setD(4'd1, 64'h0, 64'h0, 4'hF, 4'hF, 4'hF, 4'hF);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        test_reset();
        test_pass();
        test_load_use();
        test_mispredict();
        test_rnone();
        test_ext_stall();
        test_saturate();
        test_reset_mid_stall();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
